// File: rtl/vx_fill_assembler_pkg.sv
// VX_fill_pkg: shared types and helpers for the fill assembler.
//   fill_state_e      : assembler FSM states
//   fill_beats()      : beats per line from line bytes and beat width
//   fill_cnt_width()  : beat counter width, never less than 1 bit
package VX_fill_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  function automatic int fill_beats(input int line_bytes, input int mem_width);
    return (line_bytes * 8) / mem_width;
  endfunction

  function automatic int fill_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vx_fill_assembler.sv
// vx_fill_assembler: gathers MEM_DATA_WIDTH memory-response beats into one
// cache line and hands it to the bank as a single fill (data + tag).
//
// Ports
//   clk, reset                 clock, async active-high reset
//   mem_rsp_valid/data/tag     incoming beat
//   mem_rsp_ready              beat accepted when high with valid
//   fill_valid/data/tag        assembled line, tag from the first beat
//   fill_ready                 bank consumes the line
//   tag_err                    sticky beat-tag mismatch flag
//
// Build option: define FILL_TAG_CHECK_EN to compare every later beat's tag
// against the captured tag; otherwise tag_err is tied low.
//
// state   | meaning
// IDLE    | no beats held
// COLLECT | 1..BEATS-1 beats held
// FULL    | line presented on fill_*
module vx_fill_assembler
  import VX_fill_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 64,
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int TAG_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]    mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]         mem_rsp_tag,
  output logic                         mem_rsp_ready,
  output logic                         fill_valid,
  output logic [CACHE_LINE_SIZE*8-1:0] fill_data,
  output logic [TAG_WIDTH-1:0]         fill_tag,
  input  logic                         fill_ready,
  output logic                         tag_err
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = fill_beats(CACHE_LINE_SIZE, MEM_DATA_WIDTH);
  localparam int CNT_W  = fill_cnt_width(BEATS);

  if ((LINE_W % MEM_DATA_WIDTH) != 0 || MEM_DATA_WIDTH > LINE_W) begin : g_bad_cfg
    $error("vx_fill_assembler: line width %0d is not a multiple of MEM_DATA_WIDTH %0d",
           LINE_W, MEM_DATA_WIDTH);
  end

  fill_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LINE_W-1:0] line_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic accept;
  logic [CNT_W-1:0] wr_idx;

  assign fill_valid    = (state == FULL);
  assign mem_rsp_ready = ~fill_valid | fill_ready;
  assign accept        = mem_rsp_valid & mem_rsp_ready;
  assign fill_data     = line_r;
  assign fill_tag      = tag_r;

  // Only COLLECT writes at the counter; a beat taken in IDLE or in the
  // consume cycle of FULL always starts a new line at word 0.
  assign wr_idx = (state == COLLECT) ? cnt : '0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE, FULL: begin
        if (state == IDLE || fill_ready) begin
          state_n = IDLE;
          if (accept) begin
            if (BEATS == 1) begin
              state_n = FULL;
            end else begin
              state_n = COLLECT;
              cnt_n   = CNT_W'(1);
            end
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (cnt == CNT_W'(BEATS - 1)) begin
            state_n = FULL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Line buffer and tag are not reset; they are only observed with fill_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < BEATS; i++) begin
        if (wr_idx == CNT_W'(i)) begin
          line_r[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rsp_data;
        end
      end
      if (state != COLLECT) begin
        tag_r <= mem_rsp_tag;
      end
    end
  end

`ifdef FILL_TAG_CHECK_EN
  logic tag_err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_err_r <= 1'b0;
    end else if (accept && state == COLLECT && mem_rsp_tag != tag_r) begin
      tag_err_r <= 1'b1;
    end
  end

  assign tag_err = tag_err_r;
`else
  assign tag_err = 1'b0;
`endif

endmodule

// File: tb/tb_vx_fill_assembler.sv
module tb_vx_fill_assembler;

  localparam int LS    = 64;
  localparam int DW    = 128;
  localparam int TW    = 8;
  localparam int LW    = LS * 8;
  localparam int BEATS = LW / DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
  logic          fill_valid;
  logic [LW-1:0] fill_data;
  logic [TW-1:0] fill_tag;
  logic          fill_ready;
  logic          tag_err;

  always #5 clk = ~clk;

  vx_fill_assembler #(
    .CACHE_LINE_SIZE(LS),
    .MEM_DATA_WIDTH (DW),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_tag  (mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .fill_valid   (fill_valid),
    .fill_data    (fill_data),
    .fill_tag     (fill_tag),
    .fill_ready   (fill_ready),
    .tag_err      (tag_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a line is just a count of beats received so far plus
  // the words collected; a finished line waits in m_line until consumed.
  logic [LW-1:0] m_line, m_cur;
  logic [TW-1:0] m_tag, m_cur_tag;
  bit            m_pending;
  int            m_nbeats;
  bit            m_tag_err;
  bit            rec_tags;
  logic [TW-1:0] obs_tags[$];
  bit            tag_check_on;

  task automatic chk(input string name, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pending = 0;
    m_nbeats  = 0;
    m_tag_err = 0;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [TW-1:0] t, input bit fr);
    bit acc;
    @(negedge clk);
    mem_rsp_valid = v;
    mem_rsp_data  = d;
    mem_rsp_tag   = t;
    fill_ready    = fr;
    #1;
    chk("fill_valid", fill_valid, m_pending);
    chk("mem_rsp_ready", mem_rsp_ready, (!m_pending || fr));
    chk("tag_err", tag_err, m_tag_err);
    if (m_pending) begin
      chk("fill_data", fill_data, m_line);
      chk("fill_tag", fill_tag, m_tag);
    end
    acc = v && (!m_pending || fr);
    if (m_pending && fr) begin
      if (rec_tags) obs_tags.push_back(fill_tag);
      m_pending = 0;
    end
    if (acc) begin
      if (m_nbeats == 0) m_cur_tag = t;
      else if (tag_check_on && t != m_cur_tag) m_tag_err = 1;
      m_cur[m_nbeats*DW +: DW] = d;
      m_nbeats++;
      if (m_nbeats == BEATS) begin
        m_line    = m_cur;
        m_tag     = m_cur_tag;
        m_pending = 1;
        m_nbeats  = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_rsp_valid = 0;
    fill_ready    = 0;
    reset         = 1;
    #1;
    chk("rst_fill_valid", fill_valid, 1'b0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 1'b1);
    chk("rst_tag_err", tag_err, 1'b0);
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  logic [LW-1:0] t1_exp;

  initial begin
`ifdef FILL_TAG_CHECK_EN
    tag_check_on = 1;
`else
    tag_check_on = 0;
`endif
    rec_tags      = 0;
    reset         = 1;
    mem_rsp_valid = 0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    fill_ready    = 0;
    model_clear();
    #12;
    chk("init_fill_valid", fill_valid, 1'b0);
    chk("init_mem_rsp_ready", mem_rsp_ready, 1'b1);
    chk("init_tag_err", tag_err, 1'b0);
    @(negedge clk);
    reset = 0;

    // 1. single line
    step(1, pat(8'h00), 8'h5A, 1);
    step(1, pat(8'h11), 8'h5A, 1);
    step(1, pat(8'h22), 8'h5A, 1);
    step(1, pat(8'h33), 8'h5A, 1);
    step(0, '0, '0, 1);
    t1_exp = {pat(8'h33), pat(8'h22), pat(8'h11), pat(8'h00)};
    chk("t1_valid", fill_valid, 1'b1);
    chk("t1_data", fill_data, t1_exp);
    chk("t1_tag", fill_tag, 8'h5A);

    // 2. backpressure, then next beat 0 accepted in the consume cycle
    for (int i = 0; i < BEATS; i++) step(1, {4{$urandom}}, 8'h21, 0);
    for (int i = 0; i < 5; i++) step(1, {4{$urandom}}, 8'h22, 0);
    step(1, pat(8'hA0), 8'h22, 1);
    chk("t2_accept_ready", mem_rsp_ready, 1'b1);
    for (int i = 1; i < BEATS; i++) step(1, pat(8'hA0 + 8'(i)), 8'h22, 1);
    step(0, '0, '0, 0);
    chk("t2_tag", fill_tag, 8'h22);
    step(0, '0, '0, 1);

    // 3. back-to-back lines
    rec_tags = 1;
    for (int l = 1; l <= 3; l++)
      for (int b = 0; b < BEATS; b++) step(1, {4{$urandom}}, 8'(l), 1);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1);
    rec_tags = 0;
    chk("t3_nfills", 32'(obs_tags.size()), 32'd3);
    if (obs_tags.size() == 3) begin
      chk("t3_tag0", obs_tags[0], 8'd1);
      chk("t3_tag1", obs_tags[1], 8'd2);
      chk("t3_tag2", obs_tags[2], 8'd3);
    end

    // 4. gaps after beat 1
    step(1, pat(8'hC0), 8'h44, 1);
    step(1, pat(8'hC1), 8'h44, 1);
    for (int i = 0; i < 3; i++) step(0, {4{$urandom}}, 8'h00, 1);
    step(1, pat(8'hC2), 8'h44, 1);
    step(1, pat(8'hC3), 8'h44, 1);
    step(0, '0, '0, 1);
    chk("t4_data", fill_data, {pat(8'hC3), pat(8'hC2), pat(8'hC1), pat(8'hC0)});

    // 5. reset mid-line
    step(1, pat(8'hD0), 8'h66, 1);
    step(1, pat(8'hD1), 8'h66, 1);
    do_reset();
    step(0, '0, '0, 1);
    for (int i = 0; i < BEATS; i++) step(1, pat(8'hE0 + 8'(i)), 8'h77, 1);
    step(0, '0, '0, 1);
    chk("t5_data", fill_data, {pat(8'hE3), pat(8'hE2), pat(8'hE1), pat(8'hE0)});
    chk("t5_tag", fill_tag, 8'h77);

    // 6. tag mismatch on beat 2
    step(1, pat(8'hF0), 8'h5A, 1);
    step(1, pat(8'hF1), 8'h5A, 1);
    step(1, pat(8'hF2), 8'h5B, 1);
    step(1, pat(8'hF3), 8'h5A, 1);
    step(0, '0, '0, 0);
    chk("t6_tag_err", tag_err, tag_check_on);
    chk("t6_tag", fill_tag, 8'h5A);
    step(0, '0, '0, 1);
    step(0, '0, '0, 0);
    chk("t6_tag_err_sticky", tag_err, tag_check_on);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, {4{$urandom}},
           ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h3C,
           $urandom_range(0, 2) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_fill_assembler.md
# VX_fill_assembler

Collects narrow memory-response beats into one full cache line and presents it to a cache bank as a single fill (line data plus request tag). It sits between the memory response port and the bank's data/tag fill path. It is the producer side of the bank's fill write into the line-wide data store. One line buffer; backpressure on both sides via valid/ready.

## Interface
- `CACHE_LINE_SIZE`, default 64: line size in bytes; line width is `CACHE_LINE_SIZE*8`.
- `MEM_DATA_WIDTH`, default 128: beat width in bits. Must evenly divide the line width and be no larger than it.
- `TAG_WIDTH`, default 8: memory response tag width.
- Derived `BEATS = CACHE_LINE_SIZE*8/MEM_DATA_WIDTH`. The beat counter is `max(1,$clog2(BEATS))` bits wide.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `mem_rsp_valid` in 1: beat valid.
- `mem_rsp_data` in `MEM_DATA_WIDTH`: beat payload.
- `mem_rsp_tag` in `TAG_WIDTH`: tag of the line being returned.
- `mem_rsp_ready` out 1: beat accepted when high together with valid.
- `fill_valid` out 1: assembled line available.
- `fill_data` out `CACHE_LINE_SIZE*8`: assembled line.
- `fill_tag` out `TAG_WIDTH`: tag captured from the line's first beat.
- `fill_ready` in 1: bank consumes the line.
- `tag_err` out 1: sticky beat-tag mismatch flag (see Configuration).

## Operation
- States:
  - `IDLE`: no beats held.
  - `COLLECT`: 1..BEATS-1 beats held.
  - `FULL`: line presented.
- Beat `k` (0-based, counted per line) is written to `fill_data[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]`, lowest word first.
- `IDLE` on an accepted beat:
  - Capture the tag and write beat 0.
  - Go to `FULL` if `BEATS==1`, otherwise go to `COLLECT` with counter = 1.
- `COLLECT` on an accepted beat:
  - Write beat `counter` and increment the counter.
  - On the last beat (counter == BEATS-1), go to `FULL` and reset the counter to 0.
- `FULL`:
  - `fill_valid = 1`.
  - On `fill_ready`, the line is consumed. Go to `IDLE`, or if a beat is accepted in the same cycle, apply the `IDLE` rule to it.
- `mem_rsp_ready = ~fill_valid | fill_ready`. This is the only combinational input-to-output path.
- `fill_data` and `fill_tag` are stable while `fill_valid` is high and not consumed.
- Bytes not yet written in `COLLECT` are don't-care. They are never presented.

## Timing
- Reset values: state `IDLE`, counter 0, `fill_valid` 0, `tag_err` 0, `mem_rsp_ready` 1. `fill_data` and `fill_tag` are don't-care and are not reset.
- Latency: last beat accepted in cycle N → `fill_valid` high in cycle N+1.
- Throughput: one line per BEATS cycles with no bubble. The first beat of the next line can be accepted in the same cycle the current line is consumed.
- Backpressure: if `fill_ready` stays low, `mem_rsp_ready` stays low and no beat is lost or overwritten.
- `mem_rsp_valid` low in `COLLECT`: the state and counter hold indefinitely.
- Reset mid-line: the partial line is discarded and no fill is issued.

## Configuration
- `FILL_TAG_CHECK_EN` defined:
  - Each beat's tag in `COLLECT` is compared with the captured tag.
  - A mismatch sets `tag_err`, which stays set until reset.
  - The beat is still accepted and stored, and the line completes normally.
- Not defined:
  - `tag_err` is tied to 0.
  - Tags on beats after the first are ignored.
  - No comparator logic is generated.

## Structure
- Shared package `VX_fill_pkg`:
  - State enum `fill_state_e` {`IDLE`, `COLLECT`, `FULL`}.
  - Function computing `BEATS` and the counter width from the parameters.
- Single module, no sub-module: the line buffer, counter and FSM are small enough to stay inline.
- Elaboration-time check: the line width must be a multiple of `MEM_DATA_WIDTH`, otherwise error.

## Test plan
1. **Single line** (defaults, BEATS=4): beats `0x…00`, `0x…11`, `0x…22`, `0x…33` with tag 0x5A on consecutive cycles, `fill_ready`=1.
   - `fill_valid` rises one cycle after the 4th beat.
   - `fill_data` = {33,22,11,00} (beat 0 in the low bits), `fill_tag`=0x5A.
2. **Backpressure**: complete a line with `fill_ready`=0 for 5 cycles while `mem_rsp_valid`=1.
   - `mem_rsp_ready`=0 throughout and the line is held unchanged.
   - On `fill_ready`=1, the next line's beat 0 is accepted in that same cycle.
3. **Back-to-back**: 3 lines streamed continuously with `fill_ready`=1.
   - 3 fills at 4-cycle spacing, tags 1, 2, 3 in order.
4. **Gaps**: `mem_rsp_valid` deasserted for 3 cycles after beat 1.
   - Counter holds; the line completes correctly with no fill issued early.
5. **Reset mid-line**: assert reset after 2 beats.
   - Outputs return to reset values and no fill is issued.
   - A following full line of 4 beats assembles correctly.
6. **Tag check** (`FILL_TAG_CHECK_EN`): beat 2 carries tag 0x5B against captured 0x5A.
   - `tag_err`=1 from the next cycle and stays 1; the fill is still issued with tag 0x5A.
   - Without the macro, `tag_err`=0.
